// File: rtl/bus_fifo_slave.sv
// Memory-mapped FIFO slave: writes to PUSH enqueue, reads from POP dequeue,
// with status/control registers and a level interrupt on fill threshold or error flags.
module bus_fifo_slave #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 8,
    parameter int THRESH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              s_sel,
    input  logic              s_wr,
    input  logic [15:0]       s_addr,
    input  logic [DATA_W-1:0] s_din,
    output logic [DATA_W-1:0] s_dout,
    output logic              irq
);
    localparam int AW = $clog2(DEPTH);

    localparam logic [4:0] OFF_PUSH = 5'h00;
    localparam logic [4:0] OFF_POP  = 5'h01;
    localparam logic [4:0] OFF_STAT = 5'h02;
    localparam logic [4:0] OFF_CTRL = 5'h03;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr, wr_ptr_next, rd_ptr_next;
    logic [AW:0]       count, count_next;
    logic              ovf, unf, ovf_next, unf_next;
    logic              full, empty, push_en, irq_next;
    logic [DATA_W-1:0] dout_next;
    logic [AW+4:0]     stat;
    logic [4:0]        offset;
    logic              unused_addr;

    assign offset      = s_addr[4:0];
    assign unused_addr = ^s_addr[15:5];
    assign full        = (count == (AW+1)'(DEPTH));
    assign empty       = (count == '0);
    assign stat        = {count, ovf, unf, full, empty};

    // NOTE: every output of this block gets a default first, so no path leaves a
    // signal unassigned and no latch is inferred; blocking '=' is correct here.
    always_comb begin
        wr_ptr_next = wr_ptr;
        rd_ptr_next = rd_ptr;
        count_next  = count;
        ovf_next    = ovf;
        unf_next    = unf;
        push_en     = 1'b0;
        dout_next   = s_dout;

        if (s_sel) begin
            if (s_wr) begin
                case (offset)
                    OFF_PUSH: begin
                        if (!full) begin
                            push_en     = 1'b1;
                            wr_ptr_next = wr_ptr + AW'(1);
                            count_next  = count + (AW+1)'(1);
                        end else begin
                            ovf_next = 1'b1;
                        end
                    end
                    OFF_CTRL: begin
                        // Flush only rewinds pointers; stored data stays in place.
                        if (s_din[0]) begin
                            wr_ptr_next = '0;
                            rd_ptr_next = '0;
                            count_next  = '0;
                        end
                        if (s_din[1]) begin
                            ovf_next = 1'b0;
                            unf_next = 1'b0;
                        end
                    end
                    default: ;
                endcase
            end else begin
                dout_next = '0;
                case (offset)
                    OFF_POP: begin
                        if (!empty) begin
                            dout_next   = mem[rd_ptr];
                            rd_ptr_next = rd_ptr + AW'(1);
                            count_next  = count - (AW+1)'(1);
                        end else begin
                            unf_next = 1'b1;
                        end
                    end
                    OFF_STAT: dout_next = DATA_W'(stat);
                    default:  ;
                endcase
            end
        end

        irq_next = (count_next >= (AW+1)'(THRESH)) | ovf_next | unf_next;
    end

    // NOTE: sequential state uses non-blocking '<=' so all registers update
    // together from values sampled before the edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
            unf    <= 1'b0;
            s_dout <= '0;
            irq    <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr_next;
            rd_ptr <= rd_ptr_next;
            count  <= count_next;
            ovf    <= ovf_next;
            unf    <= unf_next;
            s_dout <= dout_next;
            irq    <= irq_next;
        end
    end

    // NOTE: the storage array has no reset; entries are only visible after a
    // push writes them, so clearing them would cost logic for no behaviour.
    always_ff @(posedge clk) begin
        if (push_en) mem[wr_ptr] <= s_din;
    end
endmodule

// File: tb/tb_bus_fifo_slave.sv
// Self-checking bench for bus_fifo_slave: a queue-based FIFO model predicts read data
// and irq; expected read data goes to a scoreboard and is compared when s_dout is valid.
module tb_bus_fifo_slave;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        s_sel;
    logic        s_wr;
    logic [15:0] s_addr;
    logic [63:0] s_din;
    logic [63:0] s_dout;
    logic        irq;

    int checks   = 0;
    int failures = 0;

    logic [63:0] m_fifo [$];
    logic [63:0] exp_q  [$];
    logic        m_ovf, m_unf;
    logic [63:0] m_last;

    bus_fifo_slave #(.DATA_W(64), .DEPTH(8), .THRESH(4)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .s_sel  (s_sel),
        .s_wr   (s_wr),
        .s_addr (s_addr),
        .s_din  (s_din),
        .s_dout (s_dout),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic m_irq();
        return (m_fifo.size() >= 4) || m_ovf || m_unf;
    endfunction

    function automatic logic [63:0] m_stat();
        logic [3:0] cnt;
        cnt = 4'(m_fifo.size());
        return {56'h0, cnt, m_ovf, m_unf, (m_fifo.size() == 8), (m_fifo.size() == 0)};
    endfunction

    // One bus access: model predicts from pre-access state, DUT output is checked after the edge.
    task automatic access(input string tag, input logic wr, input logic [15:0] addr,
                          input logic [63:0] din);
        logic [63:0] exp;
        s_sel = 1'b1; s_wr = wr; s_addr = addr; s_din = din;
        if (!wr) begin
            exp = 64'h0;
            case (addr[4:0])
                5'h01: if (m_fifo.size() > 0) exp = m_fifo.pop_front(); else m_unf = 1'b1;
                5'h02: exp = m_stat();
                default: ;
            endcase
            exp_q.push_back(exp);
            m_last = exp;
        end else begin
            case (addr[4:0])
                5'h00: if (m_fifo.size() < 8) m_fifo.push_back(din); else m_ovf = 1'b1;
                5'h03: begin
                    if (din[0]) m_fifo.delete();
                    if (din[1]) begin m_ovf = 1'b0; m_unf = 1'b0; end
                end
                default: ;
            endcase
        end
        @(posedge clk); #1;
        s_sel = 1'b0;
        if (!wr) begin
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL %s: scoreboard empty", tag);
            end else begin
                check({tag, ".dout"}, s_dout, exp_q.pop_front());
            end
        end else begin
            check({tag, ".dout_hold"}, s_dout, m_last);
        end
        check({tag, ".irq"}, {63'h0, irq}, {63'h0, m_irq()});
    endtask

    task automatic push(input logic [63:0] d);  access("push", 1'b1, 16'h0000, d); endtask
    task automatic pop(input string tag);        access(tag, 1'b0, 16'h0001, 64'h0); endtask
    task automatic stat(input string tag);       access(tag, 1'b0, 16'h0002, 64'h0); endtask

    initial begin
        m_ovf = 1'b0; m_unf = 1'b0; m_last = 64'h0;
        reset_n = 1'b0; s_sel = 1'b0; s_wr = 1'b0; s_addr = 16'h0; s_din = 64'h0;
        repeat (3) @(posedge clk);
        #1;
        check("reset.dout", s_dout, 64'h0);
        check("reset.irq", {63'h0, irq}, 64'h0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // 1: status after reset
        stat("t1.stat");

        // 2: simple push/pop
        push(64'h1111);
        push(64'h2222);
        pop("t2.pop0");
        pop("t2.pop1");
        stat("t2.stat");

        // 3: fill to full, overflow, drain
        for (int i = 1; i <= 8; i++) push(64'(i));
        stat("t3.stat_full");
        push(64'h9);
        stat("t3.stat_ovf");
        for (int i = 0; i < 8; i++) pop("t3.pop");
        access("t3.clr", 1'b1, 16'h0003, 64'h2);

        // 4: underflow, then clear
        pop("t4.pop_empty");
        stat("t4.stat_unf");
        access("t4.clr", 1'b1, 16'h0003, 64'h2);
        stat("t4.stat_clr");

        // 5: pointer wrap
        for (int i = 0; i < 5; i++) push(64'hA000 + 64'(i));
        for (int i = 0; i < 4; i++) pop("t5.pop_a");
        for (int i = 0; i < 6; i++) push(64'hB000 + 64'(i));
        for (int i = 0; i < 7; i++) pop("t5.pop_b");
        stat("t5.stat");

        // 6: flush, unmapped offsets, deselected writes, aliased address
        for (int i = 0; i < 3; i++) push(64'hC000 + 64'(i));
        access("t6.flush", 1'b1, 16'h0003, 64'h1);
        stat("t6.stat_flush");
        access("t6.rd_other", 1'b0, 16'h0010, 64'h0);
        access("t6.wr_other", 1'b1, 16'h0010, 64'hFFFF_FFFF_FFFF_FFFF);
        access("t6.rd_push", 1'b0, 16'h0000, 64'h0);
        access("t6.rd_ctrl", 1'b0, 16'h0003, 64'h0);
        s_sel = 1'b0; s_wr = 1'b1; s_addr = 16'h0000; s_din = 64'hDEAD;
        @(posedge clk); #1;
        stat("t6.stat_nosel");
        access("t6.alias_push", 1'b1, 16'h0120, 64'h5A5A);
        pop("t6.alias_pop");

        // randomized mix of pushes and pops
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 1) push(64'($urandom));
            else pop("rnd.pop");
        end
        stat("rnd.stat");

        // mid-operation async reset
        while (m_fifo.size() < 5) push(64'($urandom));
        access("mr.clr", 1'b1, 16'h0003, 64'h2);
        pop("mr.pop");
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst.dout", s_dout, 64'h0);
        check("midrst.irq", {63'h0, irq}, 64'h0);
        m_fifo.delete(); exp_q.delete();
        m_ovf = 1'b0; m_unf = 1'b0; m_last = 64'h0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        push(64'h7777);
        stat("midrst.stat");
        pop("midrst.pop");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
